// File: rtl/ifmp_pkg.sv
// rtl/ifmp_pkg.sv - shared types and defaults for the ifmp slave receive buffer
package ifmp_pkg;

  localparam int IFMP_DATA_W = 32;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } ifmp_state_e;

endpackage

// File: rtl/ifmp_ram.sv
// rtl/ifmp_ram.sv - DEPTH x DATA_W register array, one write port, async read port
module ifmp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; validity is tracked by the controller.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifmp_slave_rx.sv
// rtl/ifmp_slave_rx.sv - slave-side receive FIFO with first-word-fall-through output
module ifmp_slave_rx
  import ifmp_pkg::*;
#(
  parameter int DATA_W = IFMP_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      sig1,
  input  logic                   sig1_vld,
  output logic                   sig2,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf_err,
  input  logic                   clr_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  ifmp_state_e   r_state;
  ifmp_state_e   w_state_nxt;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic          r_ovf_err;
  logic          w_accept;
  logic          w_pop;
  logic          w_drop;

  // Handshake outputs come only from the registered state.
  assign sig2     = (r_state != FULL);
  assign out_vld  = (r_state != EMPTY);
  assign level    = r_level;
  assign ovf_err  = r_ovf_err;

  assign w_accept = sig1_vld & sig2;
  assign w_pop    = out_vld & out_rdy;
  assign w_drop   = sig1_vld & ~sig2;

  always_comb begin
    w_level_nxt = r_level;
    if (w_accept && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_accept) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY:   if (w_accept) w_state_nxt = PARTIAL;
      PARTIAL: begin
        if (w_level_nxt == LVL_FULL) begin
          w_state_nxt = FULL;
        end else if (w_level_nxt == '0) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL:    if (w_pop && !w_accept) w_state_nxt = PARTIAL;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      if (w_accept) r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf_err <= 1'b1;
      end else if (clr_err) begin
        r_ovf_err <= 1'b0;
      end
    end
  end

  ifmp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_accept & rst_n),
    .i_waddr (r_wptr),
    .i_wdata (sig1),
    .i_raddr (r_rptr),
    .o_rdata (out_data)
  );

endmodule

// File: tb/tb_ifmp_slave_rx.sv
// tb/tb_ifmp_slave_rx.sv - directed self-checking bench for ifmp_slave_rx
module tb_ifmp_slave_rx;
  import ifmp_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] sig1;
  logic        sig1_vld;
  logic        sig2;
  logic [31:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic [2:0]  level;
  logic        ovf_err;
  logic        clr_err;

  int n_vec;
  int n_miscmp;

  ifmp_slave_rx #(
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig1     (sig1),
    .sig1_vld (sig1_vld),
    .sig2     (sig2),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .level    (level),
    .ovf_err  (ovf_err),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    rst_n    = 1'b0;
    sig1     = '0;
    sig1_vld = 1'b0;
    out_rdy  = 1'b0;
    clr_err  = 1'b0;
    step();
    step();
    chk("rst_sig2",    32'(sig2),    32'd1);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_level",   32'(level),   32'd0);
    chk("rst_ovf_err", 32'(ovf_err), 32'd0);
    chk("rst_state",   32'(dut.r_state), 32'(EMPTY));
    rst_n = 1'b1;
    step();

    // single word
    sig1 = 32'hDEAD_BEEF;
    sig1_vld = 1'b1;
    step();
    sig1_vld = 1'b0;
    chk("one_out_vld",  32'(out_vld), 32'd1);
    chk("one_out_data", out_data,     32'hDEAD_BEEF);
    chk("one_level",    32'(level),   32'd1);
    chk("one_state",    32'(dut.r_state), 32'(PARTIAL));
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("one_drain_level",   32'(level),   32'd0);
    chk("one_drain_out_vld", 32'(out_vld), 32'd0);

    // fill to full, then overflow
    for (int i = 1; i <= 4; i++) begin
      sig1 = 32'(i);
      sig1_vld = 1'b1;
      step();
    end
    sig1_vld = 1'b0;
    chk("fill_sig2",  32'(sig2),  32'd0);
    chk("fill_level", 32'(level), 32'd4);
    chk("fill_state", 32'(dut.r_state), 32'(FULL));
    chk("fill_head",  out_data,   32'd1);
    sig1 = 32'd5;
    sig1_vld = 1'b1;
    step();
    sig1_vld = 1'b0;
    chk("ovf_err_set", 32'(ovf_err), 32'd1);
    chk("ovf_level",   32'(level),   32'd4);
    chk("ovf_head",    out_data,     32'd1);

    // clear collides with a fresh drop: set wins, then clear alone
    sig1_vld = 1'b1;
    clr_err  = 1'b1;
    step();
    sig1_vld = 1'b0;
    chk("clr_vs_set", 32'(ovf_err), 32'd1);
    chk("clr_vs_set_level", 32'(level), 32'd4);
    step();
    clr_err = 1'b0;
    chk("clr_alone", 32'(ovf_err), 32'd0);

    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fill_drain_%0d", i), out_data, 32'(i));
      out_rdy = 1'b1;
      step();
    end
    out_rdy = 1'b0;
    chk("fill_drain_level", 32'(level), 32'd0);
    chk("fill_drain_sig2",  32'(sig2),  32'd1);

    // streaming
    for (int i = 0; i < 20; i++) begin
      sig1 = 32'(i);
      sig1_vld = 1'b1;
      out_rdy = 1'b1;
      step();
      chk($sformatf("stream_level_%0d", i), 32'(level), 32'd1);
      chk($sformatf("stream_sig2_%0d", i),  32'(sig2),  32'd1);
      chk($sformatf("stream_data_%0d", i),  out_data,   32'(i));
    end
    sig1_vld = 1'b0;
    step();
    out_rdy = 1'b0;
    chk("stream_end_level", 32'(level), 32'd0);

    // wrap: three fill/drain rounds with random consumer stalls
    for (int r = 0; r < 3; r++) begin
      int popped;
      for (int k = 0; k < 4; k++) begin
        sig1 = 32'h100 + 32'(r * 4 + k);
        sig1_vld = 1'b1;
        step();
      end
      sig1_vld = 1'b0;
      chk($sformatf("wrap_full_%0d", r), 32'(level), 32'd4);
      popped = 0;
      for (int c = 0; c < 64 && popped < 4; c++) begin
        out_rdy = 1'($urandom_range(0, 1));
        if (out_vld && out_rdy) begin
          chk($sformatf("wrap_data_%0d_%0d", r, popped), out_data, 32'h100 + 32'(r * 4 + popped));
          popped++;
        end
        step();
      end
      out_rdy = 1'b0;
      chk($sformatf("wrap_popped_%0d", r), 32'(popped), 32'd4);
      chk($sformatf("wrap_empty_%0d", r),  32'(level),  32'd0);
    end

    // reset mid-stream at level 3, with a write attempted during reset
    for (int k = 0; k < 3; k++) begin
      sig1 = 32'h200 + 32'(k);
      sig1_vld = 1'b1;
      step();
    end
    chk("mid_level3", 32'(level), 32'd3);
    rst_n = 1'b0;
    sig1 = 32'h77;
    sig1_vld = 1'b1;
    step();
    chk("mid_rst_level",   32'(level),   32'd0);
    chk("mid_rst_out_vld", 32'(out_vld), 32'd0);
    chk("mid_rst_sig2",    32'(sig2),    32'd1);
    rst_n = 1'b1;
    sig1 = 32'hA5A5_A5A5;
    step();
    sig1_vld = 1'b0;
    chk("mid_first_data",  out_data,   32'hA5A5_A5A5);
    chk("mid_first_level", 32'(level), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
